// File: rtl/cos_seq.sv
// Sequencer that drives a MAC datapath and register file through one cosine-similarity accumulation.
// Optional abort input is enabled by defining COS_SEQ_ABORT_EN.
module cos_seq #(
  parameter int unsigned VLEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VLEN_W-1:0] vec_len,
  output logic              busy,
  output logic              done,
  input  logic              elem_valid,
  output logic              elem_ready,
  output logic [2:0]        alu_op,
  output logic              rf_wr_en,
  output logic [2:0]        rf_dest,
  output logic [2:0]        rf_src1,
  output logic [2:0]        rf_src2
`ifdef COS_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLR    = 3'b001;
  localparam logic [2:0] OP_MAC_AB = 3'b010;
  localparam logic [2:0] OP_MAC_AA = 3'b011;
  localparam logic [2:0] OP_MAC_BB = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;

  // Fixed register map: R0 dot, R1 sum a*a, R2 sum b*b, R3 final product.
  localparam logic [2:0] REG_DOT  = 3'd0;
  localparam logic [2:0] REG_AA   = 3'd1;
  localparam logic [2:0] REG_BB   = 3'd2;
  localparam logic [2:0] REG_PROD = 3'd3;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR0,
    CLEAR1,
    CLEAR2,
    FETCH,
    MAC_AB,
    MAC_AA,
    MAC_BB,
    FINAL,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [VLEN_W-1:0] remaining_q, remaining_d;
  logic              abort_act;

`ifdef COS_SEQ_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    elem_ready  = 1'b0;
    alu_op      = OP_NOP;
    rf_wr_en    = 1'b0;
    rf_dest     = 3'd0;
    rf_src1     = 3'd0;
    rf_src2     = 3'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = vec_len;
          state_d     = CLEAR0;
        end
      end
      CLEAR0: begin
        alu_op   = OP_CLR;
        rf_wr_en = 1'b1;
        rf_dest  = REG_DOT;
        state_d  = CLEAR1;
      end
      CLEAR1: begin
        alu_op   = OP_CLR;
        rf_wr_en = 1'b1;
        rf_dest  = REG_AA;
        state_d  = CLEAR2;
      end
      CLEAR2: begin
        alu_op   = OP_CLR;
        rf_wr_en = 1'b1;
        rf_dest  = REG_BB;
        state_d  = (remaining_q == '0) ? FINAL : FETCH;
      end
      FETCH: begin
        elem_ready = 1'b1;
        if (elem_valid) begin
          state_d = MAC_AB;
        end
      end
      MAC_AB: begin
        alu_op   = OP_MAC_AB;
        rf_wr_en = 1'b1;
        rf_src1  = REG_DOT;
        rf_dest  = REG_DOT;
        state_d  = MAC_AA;
      end
      MAC_AA: begin
        alu_op   = OP_MAC_AA;
        rf_wr_en = 1'b1;
        rf_src1  = REG_AA;
        rf_dest  = REG_AA;
        state_d  = MAC_BB;
      end
      MAC_BB: begin
        alu_op      = OP_MAC_BB;
        rf_wr_en    = 1'b1;
        rf_src1     = REG_BB;
        rf_dest     = REG_BB;
        remaining_d = remaining_q - VLEN_W'(1);
        // Decide on the pre-decrement value so the last element exits without wrapping.
        state_d     = (remaining_q == VLEN_W'(1)) ? FINAL : FETCH;
      end
      FINAL: begin
        alu_op   = OP_MUL;
        rf_wr_en = 1'b1;
        rf_src1  = REG_AA;
        rf_src2  = REG_BB;
        rf_dest  = REG_PROD;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort suppresses any write or handshake in the very cycle it is seen.
    if (abort_act) begin
      rf_wr_en    = 1'b0;
      elem_ready  = 1'b0;
      remaining_d = '0;
      state_d     = IDLE;
    end
  end

endmodule

// File: tb/tb_cos_seq.sv
// Directed self-checking bench for cos_seq; expected output vectors are hand-built per sequencer state.
// Define COS_SEQ_ABORT_EN for both files to also exercise the abort feature.
module tb_cos_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] vecLen;
   logic       busy;
   logic       done;
   logic       elemValid;
   logic       elemReady;
   logic [2:0] aluOp;
   logic       rfWrEn;
   logic [2:0] rfDest;
   logic [2:0] rfSrc1;
   logic [2:0] rfSrc2;
`ifdef COS_SEQ_ABORT_EN
   logic       abort;
`endif

   int nAsserts = 0;
   int nFails   = 0;

   // Output vector layout: busy, done, elem_ready, alu_op[3], rf_wr_en, rf_dest[3], rf_src1[3], rf_src2[3]
   localparam logic [15:0] E_IDLE  = {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
   localparam logic [15:0] E_CLR0  = {1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 3'd0, 3'd0, 3'd0};
   localparam logic [15:0] E_CLR1  = {1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 3'd1, 3'd0, 3'd0};
   localparam logic [15:0] E_CLR2  = {1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 3'd2, 3'd0, 3'd0};
   localparam logic [15:0] E_FETCH = {1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
   localparam logic [15:0] E_MAB   = {1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 3'd0, 3'd0};
   localparam logic [15:0] E_MAA   = {1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'd1, 3'd1, 3'd0};
   localparam logic [15:0] E_MBB   = {1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 3'd2, 3'd2, 3'd0};
   localparam logic [15:0] E_FIN   = {1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 3'd3, 3'd1, 3'd2};
   localparam logic [15:0] E_DONE  = {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
`ifdef COS_SEQ_ABORT_EN
   localparam logic [15:0] E_ABORT_FETCH = {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
`endif

   cos_seq #(.VLEN_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vec_len    (vecLen),
      .busy       (busy),
      .done       (done),
      .elem_valid (elemValid),
      .elem_ready (elemReady),
      .alu_op     (aluOp),
      .rf_wr_en   (rfWrEn),
      .rf_dest    (rfDest),
      .rf_src1    (rfSrc1),
      .rf_src2    (rfSrc2)
`ifdef COS_SEQ_ABORT_EN
      ,
      .abort      (abort)
`endif
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to the next cycle and settle 1 unit past the rising edge
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Compare the whole output bundle against a hand-built state vector
   task automatic checkOutput(input string tag, input logic [15:0] expected);
      logic [15:0] observed;
      observed = {busy, done, elemReady, aluOp, rfWrEn, rfDest, rfSrc1, rfSrc2};
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Compare a scalar count observed by the bench
   task automatic checkValue(input string tag, input int observed, input int expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Present start with a length in cycle 0, then move to cycle 1 with start dropped
   task automatic applyStimulus(input logic [7:0] len);
      vecLen = len;
      start  = 1'b1;
      nextCycle();
      start  = 1'b0;
   endtask

   initial begin
      logic [15:0] seq25 [14];
      logic [15:0] seq26 [6];
      int          dones;
      int          c;

      rst       = 1'b1;
      start     = 1'b0;
      vecLen    = 8'd0;
      elemValid = 1'b0;
`ifdef COS_SEQ_ABORT_EN
      abort     = 1'b0;
`endif

      // Reset state
      nextCycle();
      nextCycle();
      checkOutput("reset_idle", E_IDLE);
      rst = 1'b0;
      nextCycle();
      checkOutput("post_reset_idle", E_IDLE);

      // vec_len=2 with elem_valid always high: cycle-by-cycle trace
      seq25 = '{E_CLR0, E_CLR1, E_CLR2, E_FETCH, E_MAB, E_MAA, E_MBB,
                E_FETCH, E_MAB, E_MAA, E_MBB, E_FIN, E_DONE, E_IDLE};
      elemValid = 1'b1;
      applyStimulus(8'd2);
      for (int i = 0; i < 14; i++) begin
         checkOutput($sformatf("len2_cycle%0d", i + 1), seq25[i]);
         nextCycle();
      end

      // vec_len=0 skips every FETCH/MAC state
      seq26 = '{E_CLR0, E_CLR1, E_CLR2, E_FIN, E_DONE, E_IDLE};
      applyStimulus(8'd0);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("len0_cycle%0d", i + 1), seq26[i]);
         nextCycle();
      end

      // vec_len=1 with elem_valid low for 10 cycles in FETCH
      elemValid = 1'b0;
      applyStimulus(8'd1);
      checkOutput("stall_clr0", E_CLR0);
      nextCycle();
      checkOutput("stall_clr1", E_CLR1);
      nextCycle();
      checkOutput("stall_clr2", E_CLR2);
      nextCycle();
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("stall_fetch%0d", i), E_FETCH);
         nextCycle();
      end
      elemValid = 1'b1;
      checkOutput("stall_fetch_valid", E_FETCH);
      nextCycle();
      checkOutput("stall_mab", E_MAB);
      nextCycle();
      checkOutput("stall_maa", E_MAA);
      nextCycle();
      checkOutput("stall_mbb", E_MBB);
      nextCycle();
      checkOutput("stall_final", E_FIN);
      nextCycle();
      checkOutput("stall_done", E_DONE);
      nextCycle();
      checkOutput("stall_idle", E_IDLE);

      // vec_len=3 with a stray start in MAC_AA that must be ignored
      dones = 0;
      applyStimulus(8'd3);
      for (int k = 1; k <= 20; k++) begin
         if (k == 6) begin
            checkOutput("restart_in_maa", E_MAA);
            start  = 1'b1;
            vecLen = 8'd7;
         end else begin
            start = 1'b0;
         end
         if (done) dones++;
         if (k == 16) checkOutput("restart_final", E_FIN);
         if (k == 17) checkOutput("restart_done", E_DONE);
         nextCycle();
      end
      checkOutput("restart_idle", E_IDLE);
      checkValue("restart_done_count", dones, 1);

      // Reset asserted in MAC_AB of a vec_len=4 run
      applyStimulus(8'd4);
      for (int k = 1; k < 5; k++) nextCycle();
      checkOutput("rst_in_mab_before", E_MAB);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_idle", E_IDLE);
      nextCycle();
      rst   = 1'b0;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         if (done) dones++;
         nextCycle();
      end
      checkValue("rst_no_done", dones, 0);
      applyStimulus(8'd1);
      for (int k = 1; k <= 10; k++) begin
         if (done) dones++;
         if (k == 8) checkOutput("rst_rerun_final", E_FIN);
         if (k == 9) checkOutput("rst_rerun_done", E_DONE);
         nextCycle();
      end
      checkValue("rst_rerun_done_count", dones, 1);

      // Maximum length must finish on cycle 4 + 4*255 + 1 without counter wrap
      applyStimulus(8'd255);
      c = 1;
      while (!done && c < 1200) begin
         nextCycle();
         c++;
      end
      checkValue("max_len_done_cycle", c, 1025);
      checkOutput("max_len_done", E_DONE);
      nextCycle();
      checkOutput("max_len_idle", E_IDLE);

`ifdef COS_SEQ_ABORT_EN
      // Abort in IDLE alongside start has no effect
      abort     = 1'b1;
      elemValid = 1'b0;
      applyStimulus(8'd5);
      abort = 1'b0;
      #1;
      checkOutput("abort_idle_ignored", E_CLR0);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("abort_pre_fetch", E_FETCH);
      elemValid = 1'b1;
      abort     = 1'b1;
      #1;
      checkOutput("abort_in_fetch", E_ABORT_FETCH);
      nextCycle();
      abort = 1'b0;
      checkOutput("abort_next_idle", E_IDLE);
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         if (done) dones++;
         nextCycle();
      end
      checkValue("abort_no_done", dones, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
